// File: rtl/cpu_clk_pkg.sv
// Shared definitions for the CPU run-control block: switch encodings and
// the push-button debounce state machine encoding.
package cpu_clk_pkg;

  localparam logic [1:0] MODE_STOP = 2'b00;
  localparam logic [1:0] MODE_SLOW = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;
  localparam logic [1:0] MODE_FAST = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } db_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Synchronises a bouncy push-button and emits a single-cycle pulse once the
// press has been stable for DEBOUNCE_CYCLES; the release must also be stable.
module btn_debounce
  import cpu_clk_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic pulse
);

  localparam int CNT_BITS = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic                btn_meta;
  logic                btn_sync;
  logic [CNT_BITS-1:0] cnt;
  db_state_t           state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
    end
  end

  // pulse is set on the transition into PRESSED so it is high exactly while in PRESSED
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_sync) begin
            cnt   <= '0;
            state <= WAIT_PRESS;
          end
        end
        WAIT_PRESS: begin
          if (!btn_sync) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state <= PRESSED;
            pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          cnt   <= '0;
          state <= WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (btn_sync) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU run control: turns the 1 Hz square wave, step button and mode switches
// into a single-cycle clock enable on clk and counts the enabled cycles.
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_slow,
  input  logic             step_btn,
  input  logic [1:0]       mode,
  input  logic             halt,
  output logic             cpu_ce,
  output logic [CNT_W-1:0] cycle_cnt
);

  logic       slow_meta;
  logic       sync_slow;
  logic       slow_d;
  logic [1:0] mode_meta;
  logic [1:0] sync_mode;
  logic       slow_tick;
  logic       step_pulse;
  logic       ce_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slow_meta <= 1'b0;
      sync_slow <= 1'b0;
      slow_d    <= 1'b0;
      mode_meta <= MODE_STOP;
      sync_mode <= MODE_STOP;
    end else begin
      slow_meta <= clk_slow;
      sync_slow <= slow_meta;
      slow_d    <= sync_slow;
      mode_meta <= mode;
      sync_mode <= mode_meta;
    end
  end

  // only rising edges of the slow clock produce a tick
  assign slow_tick = sync_slow & ~slow_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (step_btn),
    .pulse   (step_pulse)
  );

  // unselected ticks and pulses simply fall through and are lost
  always_comb begin
    ce_next = 1'b0;
    if (!halt) begin
      case (sync_mode)
        MODE_STOP: ce_next = 1'b0;
        MODE_SLOW: ce_next = slow_tick;
        MODE_STEP: ce_next = step_pulse;
        MODE_FAST: ce_next = 1'b1;
        default:   ce_next = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_ce    <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      cpu_ce <= ce_next;
      if (cpu_ce) begin
        cycle_cnt <= cycle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Scoreboard bench for cpu_clk_ctrl: expected cpu_ce/cycle_cnt per cycle are
// queued from the stimulus schedule and popped after every clock edge.
module tb_cpu_clk_ctrl;
  import cpu_clk_pkg::*;

  localparam int DEB = 4;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_slow;
  logic          step_btn;
  logic [1:0]    mode;
  logic          halt;
  logic          cpu_ce;
  logic [CW-1:0] cycle_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          ce;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb_q[$];
  logic          m_ce;
  logic [CW-1:0] m_cnt;

  cpu_clk_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_slow  (clk_slow),
    .step_btn  (step_btn),
    .mode      (mode),
    .halt      (halt),
    .cpu_ce    (cpu_ce),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  // the counter seen after an edge is the previous count plus the previous enable
  function automatic void sb_push(input logic ce);
    exp_t e;
    e.ce  = ce;
    e.cnt = m_cnt + {{(CW-1){1'b0}}, m_ce};
    sb_q.push_back(e);
    m_cnt = e.cnt;
    m_ce  = ce;
  endfunction

  function automatic logic slow_at(input int i);
    return (i >= 10) && (((i - 10) / 20) % 2 == 0);
  endfunction

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    mode  = MODE_FAST;
    @(posedge clk); #1;
    checks++; if (cpu_ce !== 1'b0) begin errors++; $display("[TB] FAIL reset_ce got %b exp 0", cpu_ce); end
    checks++; if (cycle_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_cnt got %0d exp 0", cycle_cnt); end
    reset = 1'b0;
    m_ce  = 1'b0;
    m_cnt = '0;
    for (int i = 0; i < 8; i++) sb_push(i >= 2);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++; if (cpu_ce !== e.ce) begin errors++; $display("[TB] FAIL run_ce cyc %0d got %b exp %b", i, cpu_ce, e.ce); end
      checks++; if (cycle_cnt !== e.cnt) begin errors++; $display("[TB] FAIL run_cnt cyc %0d got %0d exp %0d", i, cycle_cnt, e.cnt); end
    end
    reset = 1'b1;
    #1;
    checks++; if (cpu_ce !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_ce got %b exp 0", cpu_ce); end
    checks++; if (cycle_cnt !== 8'd0) begin errors++; $display("[TB] FAIL async_reset_cnt got %0d exp 0", cycle_cnt); end
    @(posedge clk); #1;
    reset = 1'b0;
    m_ce  = 1'b0;
    m_cnt = '0;
    for (int i = 0; i < 13; i++) sb_push(i >= 2);
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++; if (cpu_ce !== e.ce) begin errors++; $display("[TB] FAIL rerun_ce cyc %0d got %b exp %b", i, cpu_ce, e.ce); end
      checks++; if (cycle_cnt !== e.cnt) begin errors++; $display("[TB] FAIL rerun_cnt cyc %0d got %0d exp %0d", i, cycle_cnt, e.cnt); end
    end
    checks++; if (cycle_cnt !== 8'd10) begin errors++; $display("[TB] FAIL ten_cycles got %0d exp 10", cycle_cnt); end
  endtask

  task automatic test_slow();
    exp_t e;
    for (int i = 0; i < 115; i++) sb_push((i < 2) ? 1'b1 : (slow_at(i - 2) && !slow_at(i - 3)));
    for (int i = 0; i < 115; i++) begin
      mode     = MODE_SLOW;
      clk_slow = slow_at(i);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++; if (cpu_ce !== e.ce) begin errors++; $display("[TB] FAIL slow_ce cyc %0d got %b exp %b", i, cpu_ce, e.ce); end
      checks++; if (cycle_cnt !== e.cnt) begin errors++; $display("[TB] FAIL slow_cnt cyc %0d got %0d exp %0d", i, cycle_cnt, e.cnt); end
    end
  endtask

  task automatic test_step_bounce();
    exp_t e;
    for (int i = 0; i < 75; i++) sb_push(i == 16);
    for (int i = 0; i < 75; i++) begin
      mode     = MODE_STEP;
      step_btn = (i == 5) || (i == 7) || (i >= 9 && i <= 58);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++; if (cpu_ce !== e.ce) begin errors++; $display("[TB] FAIL bounce_ce cyc %0d got %b exp %b", i, cpu_ce, e.ce); end
      checks++; if (cycle_cnt !== e.cnt) begin errors++; $display("[TB] FAIL bounce_cnt cyc %0d got %0d exp %0d", i, cycle_cnt, e.cnt); end
    end
    step_btn = 1'b0;
  endtask

  task automatic test_step_glitch();
    exp_t e;
    for (int i = 0; i < 60; i++) sb_push((i == 22) || (i == 47));
    for (int i = 0; i < 60; i++) begin
      mode     = MODE_STEP;
      step_btn = (i == 3) || (i == 4) || (i >= 15 && i <= 24) || (i >= 40 && i <= 49);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++; if (cpu_ce !== e.ce) begin errors++; $display("[TB] FAIL glitch_ce cyc %0d got %b exp %b", i, cpu_ce, e.ce); end
      checks++; if (cycle_cnt !== e.cnt) begin errors++; $display("[TB] FAIL glitch_cnt cyc %0d got %0d exp %0d", i, cycle_cnt, e.cnt); end
    end
    step_btn = 1'b0;
  endtask

  task automatic test_halt();
    exp_t e;
    for (int i = 0; i < 15; i++) sb_push((i >= 2) && !(i >= 5 && i <= 9));
    for (int i = 0; i < 15; i++) begin
      mode = MODE_FAST;
      halt = (i >= 5 && i <= 9);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++; if (cpu_ce !== e.ce) begin errors++; $display("[TB] FAIL halt_ce cyc %0d got %b exp %b", i, cpu_ce, e.ce); end
      checks++; if (cycle_cnt !== e.cnt) begin errors++; $display("[TB] FAIL halt_cnt cyc %0d got %0d exp %0d", i, cycle_cnt, e.cnt); end
    end
    halt = 1'b0;
  endtask

  task automatic test_wrap_stop();
    exp_t e;
    reset = 1'b1;
    #1;
    checks++; if (cycle_cnt !== 8'd0) begin errors++; $display("[TB] FAIL wrap_reset_cnt got %0d exp 0", cycle_cnt); end
    @(posedge clk); #1;
    reset = 1'b0;
    m_ce  = 1'b0;
    m_cnt = '0;
    for (int i = 0; i < 300; i++) sb_push((i >= 2) && (i < 265));
    for (int i = 0; i < 300; i++) begin
      mode     = (i < 263) ? MODE_FAST : MODE_STOP;
      clk_slow = (i >= 270 && i <= 279) || (i >= 290);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++; if (cpu_ce !== e.ce) begin errors++; $display("[TB] FAIL wrap_ce cyc %0d got %b exp %b", i, cpu_ce, e.ce); end
      checks++; if (cycle_cnt !== e.cnt) begin errors++; $display("[TB] FAIL wrap_cnt cyc %0d got %0d exp %0d", i, cycle_cnt, e.cnt); end
      if (i == 262) begin
        checks++; if (cycle_cnt !== 8'd4) begin errors++; $display("[TB] FAIL wrap_end got %0d exp 4", cycle_cnt); end
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    clk_slow = 1'b0;
    step_btn = 1'b0;
    mode     = MODE_STOP;
    halt     = 1'b0;
    m_ce     = 1'b0;
    m_cnt    = '0;
    test_reset();
    test_slow();
    test_step_bounce();
    test_step_glitch();
    test_halt();
    test_wrap_stop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
